// File: rtl/dphy_pkg.sv
// Shared D-PHY lane definitions: clock-lane FSM states, LP line codes and a small helper.
// Optional ULPS support is compiled in with DPHY_CLK_ULPS_EN.
package dphy_pkg;

    // LP line levels as {Dp,Dn}
    localparam logic [1:0] LP_STOP    = 2'b11;
    localparam logic [1:0] LP_HS_RQ   = 2'b01;
    localparam logic [1:0] LP_ULPS_RQ = 2'b10;
    localparam logic [1:0] LP_BRIDGE  = 2'b00;

    typedef enum logic [3:0] {
        StInit,
        StStop,
        StHsRqst,
        StHsPrpr,
        StHsClk,
        StHsEnd,
        StErr
`ifdef DPHY_CLK_ULPS_EN
        ,
        StUlpsRqst,
        StUlps,
        StUlpsExit
`endif
    } clk_lane_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lp_filter.sv
// LP comparator conditioning: 2-FF synchronizer followed by a stability filter.
// The filtered value only moves after the synced sample has held a new value for
// LP_FILTER_TICKS consecutive cycles, so lp_i-to-output latency is 2+LP_FILTER_TICKS.
module lp_filter #(
    parameter int unsigned LP_FILTER_TICKS = 2
) (
    input  logic       ref_clk_i,
    input  logic       rst_i,
    input  logic [1:0] lp_i,
    output logic [1:0] lp_filt_o
);

    localparam int unsigned CntW = $clog2(LP_FILTER_TICKS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(LP_FILTER_TICKS);

    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      cand_q, filt_q;
    logic [CntW-1:0] cnt_q, cnt_next;

    // Run length of the candidate value including this cycle; restarts on a new value
    always_comb begin
        cnt_next = (sync2_q == cand_q) ? cnt_q + 1'b1 : CntW'(1);
    end

    // Synchronizer, candidate tracking and filtered-value update
    always_ff @(posedge ref_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            cand_q  <= 2'b00;
            filt_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            sync1_q <= lp_i;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_next >= CntMax) begin
                filt_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cand_q <= sync2_q;
                cnt_q  <= cnt_next;
            end
        end
    end

    assign lp_filt_o = filt_q;

endmodule

// File: rtl/dphy_clk_lane_fsm.sv
// D-PHY receiver clock-lane control FSM (ref_clk_i domain).
// Walks LP-11 -> LP-01 -> LP-00 -> HS clock -> LP-11, drives HS termination and
// reports HS clock activity, stop state and control errors. Outputs are registered
// from the current state, so they trail the state register by one cycle.
// Define DPHY_CLK_ULPS_EN to add the ULPS request/active/exit states.
module dphy_clk_lane_fsm
    import dphy_pkg::*;
#(
    parameter int unsigned LP_FILTER_TICKS = 2,
    parameter int unsigned TERM_EN_TICKS   = 4,
    parameter int unsigned SETTLE_TIMEOUT  = 64,
    parameter int unsigned END_TIMEOUT     = 64
) (
    input  logic       ref_clk_i,
    input  logic       rst_i,
    input  logic [1:0] lp_i,
    input  logic       clk_present_i,
    output logic       hs_term_en_o,
    output logic       rxclkactivehs_o,
    output logic       stopstate_o,
    output logic       ulps_active_o,
    output logic       err_ctrl_o
);

    localparam int unsigned TmrMax = max3(TERM_EN_TICKS, SETTLE_TIMEOUT, END_TIMEOUT);
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam logic [TmrW-1:0] TermEnTicks   = TmrW'(TERM_EN_TICKS);
    localparam logic [TmrW-1:0] SettleTimeout = TmrW'(SETTLE_TIMEOUT);
    localparam logic [TmrW-1:0] EndTimeout    = TmrW'(END_TIMEOUT);

    logic [1:0]      lp_filt;
    clk_lane_state_t state_q, state_d;
    logic [TmrW-1:0] timer_q;

    lp_filter #(
        .LP_FILTER_TICKS(LP_FILTER_TICKS)
    ) u_lp_filter (
        .ref_clk_i(ref_clk_i),
        .rst_i    (rst_i),
        .lp_i     (lp_i),
        .lp_filt_o(lp_filt)
    );

    // Next-state decode; LP-11 outranks clk_present which outranks the timeouts
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit: begin
                if (lp_filt == LP_STOP) state_d = StStop;
            end
            StStop: begin
                if (lp_filt == LP_HS_RQ) state_d = StHsRqst;
`ifdef DPHY_CLK_ULPS_EN
                else if (lp_filt == LP_ULPS_RQ) state_d = StUlpsRqst;
`else
                else if (lp_filt == LP_ULPS_RQ) state_d = StErr;
`endif
                else if (lp_filt == LP_BRIDGE) state_d = StErr;
            end
            StHsRqst: begin
                if (lp_filt == LP_BRIDGE) state_d = StHsPrpr;
                else if (lp_filt == LP_STOP) state_d = StStop;
                else if (lp_filt == LP_ULPS_RQ) state_d = StErr;
            end
            StHsPrpr: begin
                if (lp_filt == LP_STOP) state_d = StStop;
                else if (clk_present_i) state_d = StHsClk;
                else if (timer_q == SettleTimeout) state_d = StErr;
            end
            StHsClk: begin
                if (!clk_present_i || lp_filt == LP_STOP) state_d = StHsEnd;
            end
            StHsEnd: begin
                if (lp_filt == LP_STOP) state_d = StStop;
                else if (timer_q == EndTimeout) state_d = StErr;
            end
            StErr: begin
                if (lp_filt == LP_STOP) state_d = StStop;
            end
`ifdef DPHY_CLK_ULPS_EN
            StUlpsRqst: begin
                if (lp_filt == LP_BRIDGE) state_d = StUlps;
                else if (lp_filt == LP_STOP) state_d = StStop;
            end
            StUlps: begin
                if (lp_filt == LP_ULPS_RQ) state_d = StUlpsExit;
            end
            StUlpsExit: begin
                if (lp_filt == LP_STOP) state_d = StStop;
            end
`endif
            default: state_d = StErr;
        endcase
    end

    // State, dwell timer and registered outputs; reset drops termination immediately
    always_ff @(posedge ref_clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q         <= StInit;
            timer_q         <= '0;
            hs_term_en_o    <= 1'b0;
            rxclkactivehs_o <= 1'b0;
            stopstate_o     <= 1'b0;
            err_ctrl_o      <= 1'b0;
`ifdef DPHY_CLK_ULPS_EN
            ulps_active_o   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + 1'b1;
            end
            hs_term_en_o    <= (state_q == StHsPrpr && timer_q >= TermEnTicks) ||
                               state_q == StHsClk || state_q == StHsEnd;
            rxclkactivehs_o <= (state_q == StHsClk);
            stopstate_o     <= (state_q == StStop) && (lp_filt == LP_STOP);
            // Timer is zero only in the first ERR cycle since it saturates afterwards
            err_ctrl_o      <= (state_q == StErr) && (timer_q == '0);
`ifdef DPHY_CLK_ULPS_EN
            ulps_active_o   <= (state_q == StUlps);
`endif
        end
    end

`ifndef DPHY_CLK_ULPS_EN
    assign ulps_active_o = 1'b0;
`endif

endmodule
